iq_mixer_decim: RTL and testbench

- Downstream consumer of the NCO sine/cos outputs.
- Mixes a real input sample stream against the NCO cosine and sine to form I and Q.
- Integrates-and-dumps I and Q over a programmable number of valid samples, then scales and saturates the result to a baseband pair with a one-cycle valid strobe.
- Sits between the NCO/ADC front end and downstream filtering/demodulation.

---
 rtl/iq_mixer_decim.sv | 137 +++++++++++++
 tb/tb_iq_mixer_decim.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_mixer_decim.sv
`default_nettype none
// ------------------------------------------------------------------------
// iq_mixer_decim : real-to-IQ mixer with integrate-and-dump decimation
// Rev 1.0
// ------------------------------------------------------------------------
module iq_mixer_decim #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int WAVE_WIDTH   = 16,
   parameter int OUTPUT_WIDTH = 16,
   parameter int MAX_DECIM    = 256,
   parameter int OUT_SHIFT    = 15
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [SAMPLE_WIDTH-1:0]      sample_in,
   input  logic                         sample_valid,
   input  logic [WAVE_WIDTH-1:0]        cos_in,
   input  logic [WAVE_WIDTH-1:0]        sin_in,
   input  logic [$clog2(MAX_DECIM):0]   decim_ratio,
   input  logic                         clear,
   output logic [OUTPUT_WIDTH-1:0]      i_out,
   output logic [OUTPUT_WIDTH-1:0]      q_out,
   output logic                         out_valid,
   output logic                         overflow
);

   localparam int c_prod_w  = SAMPLE_WIDTH + WAVE_WIDTH;
   localparam int c_acc_w   = c_prod_w + $clog2(MAX_DECIM);
   localparam int c_ratio_w = $clog2(MAX_DECIM) + 1;
   localparam logic [c_ratio_w-1:0] c_ratio_max = c_ratio_w'(MAX_DECIM);
   localparam logic signed [c_acc_w-1:0] c_out_max =
      {{(c_acc_w-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
   localparam logic signed [c_acc_w-1:0] c_out_min =
      {{(c_acc_w-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

   logic signed [c_prod_w-1:0]  w_s_ext, w_c_ext, w_sn_ext, w_p_i, w_p_q;
   logic signed [c_prod_w-1:0]  prod_i_q, prod_q_q;
   logic                        p_valid_q;
   logic signed [c_acc_w-1:0]   acc_i_q, acc_q_q;
   logic signed [c_acc_w-1:0]   w_pe_i, w_pe_q, w_sum_i, w_sum_q, w_sh_i, w_sh_q;
   logic [c_ratio_w-1:0]        cnt_q, ratio_q, w_ratio_new, w_ratio_eff;
   logic                        w_dump, w_clip;
   logic [OUTPUT_WIDTH-1:0]     i_out_q, q_out_q;
   logic                        out_valid_q, overflow_q;

   // Operands are sign-extended to the full product width so the multiply is width-matched.
   assign w_s_ext  = {{WAVE_WIDTH{sample_in[SAMPLE_WIDTH-1]}}, sample_in};
   assign w_c_ext  = {{SAMPLE_WIDTH{cos_in[WAVE_WIDTH-1]}}, cos_in};
   assign w_sn_ext = {{SAMPLE_WIDTH{sin_in[WAVE_WIDTH-1]}}, sin_in};
   assign w_p_i    = w_s_ext * w_c_ext;
   assign w_p_q    = w_s_ext * w_sn_ext;

   always_comb begin
      w_ratio_new = decim_ratio;
      if (decim_ratio == '0)
         w_ratio_new = c_ratio_w'(1);
      else if (decim_ratio > c_ratio_max)
         w_ratio_new = c_ratio_max;
   end

   // The first sample of a period uses the ratio being latched in the same cycle.
   assign w_ratio_eff = (cnt_q == '0) ? w_ratio_new : ratio_q;
   assign w_dump      = p_valid_q && (cnt_q == w_ratio_eff - c_ratio_w'(1));

   assign w_pe_i  = {{(c_acc_w-c_prod_w){prod_i_q[c_prod_w-1]}}, prod_i_q};
   assign w_pe_q  = {{(c_acc_w-c_prod_w){prod_q_q[c_prod_w-1]}}, prod_q_q};
   assign w_sum_i = acc_i_q + w_pe_i;
   assign w_sum_q = acc_q_q + w_pe_q;
   assign w_sh_i  = w_sum_i >>> OUT_SHIFT;
   assign w_sh_q  = w_sum_q >>> OUT_SHIFT;
   assign w_clip  = (w_sh_i > c_out_max) || (w_sh_i < c_out_min) ||
                    (w_sh_q > c_out_max) || (w_sh_q < c_out_min);

   function automatic logic [OUTPUT_WIDTH-1:0] sat(input logic signed [c_acc_w-1:0] v);
      if (v > c_out_max)
         return c_out_max[OUTPUT_WIDTH-1:0];
      else if (v < c_out_min)
         return c_out_min[OUTPUT_WIDTH-1:0];
      else
         return v[OUTPUT_WIDTH-1:0];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_i_q    <= '0;
         prod_q_q    <= '0;
         p_valid_q   <= 1'b0;
         acc_i_q     <= '0;
         acc_q_q     <= '0;
         cnt_q       <= '0;
         ratio_q     <= '0;
         i_out_q     <= '0;
         q_out_q     <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else if (clear) begin
         p_valid_q   <= 1'b0;
         acc_i_q     <= '0;
         acc_q_q     <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         p_valid_q   <= sample_valid;
         out_valid_q <= 1'b0;
         if (sample_valid) begin
            prod_i_q <= w_p_i;
            prod_q_q <= w_p_q;
         end
         if (p_valid_q) begin
            if (cnt_q == '0)
               ratio_q <= w_ratio_new;
            if (w_dump) begin
               i_out_q     <= sat(w_sh_i);
               q_out_q     <= sat(w_sh_q);
               out_valid_q <= 1'b1;
               if (w_clip)
                  overflow_q <= 1'b1;
               acc_i_q     <= '0;
               acc_q_q     <= '0;
               cnt_q       <= '0;
            end else begin
               acc_i_q <= w_sum_i;
               acc_q_q <= w_sum_q;
               cnt_q   <= cnt_q + c_ratio_w'(1);
            end
         end
      end
   end

   assign i_out     = i_out_q;
   assign q_out     = q_out_q;
   assign out_valid = out_valid_q;
   assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_iq_mixer_decim.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_iq_mixer_decim : scoreboard bench for iq_mixer_decim
// Rev 1.0
// ------------------------------------------------------------------------
module tb_iq_mixer_decim;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sample_in, cos_in, sin_in;
   logic        sample_valid, clear;
   logic [8:0]  decim_ratio;
   logic [15:0] i_out, q_out;
   logic        out_valid, overflow;

   iq_mixer_decim dut (
      .clk          (clk),
      .rst          (rst),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .cos_in       (cos_in),
      .sin_in       (sin_in),
      .decim_ratio  (decim_ratio),
      .clear        (clear),
      .i_out        (i_out),
      .q_out        (q_out),
      .out_valid    (out_valid),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint i;
      longint q;
      bit     ovf;
   } exp_t;

   exp_t   sb[$];
   int     n_vec = 0;
   int     n_err = 0;
   longint cyc = 0;
   int     exp_interval = 0;
   longint last_ov = 0;
   bit     have_last = 0;

   longint m_acc_i, m_acc_q;
   int     m_cnt, m_ratio;
   bit     m_ovf;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint act, input longint exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp_v, $time);
      end
   endtask

   function automatic longint satm(input longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int clamp_ratio(input int r);
      if (r == 0)   return 1;
      if (r > 256)  return 256;
      return r;
   endfunction

   task automatic model_flush();
      m_acc_i = 0;
      m_acc_q = 0;
      m_cnt   = 0;
      m_ovf   = 0;
   endtask

   task automatic model_sample(input int s, input int c, input int sn);
      longint si, sq;
      exp_t   e;
      if (m_cnt == 0) m_ratio = clamp_ratio(int'(decim_ratio));
      m_acc_i += longint'(s) * longint'(c);
      m_acc_q += longint'(s) * longint'(sn);
      m_cnt++;
      if (m_cnt == m_ratio) begin
         si = m_acc_i >>> 15;
         sq = m_acc_q >>> 15;
         if (satm(si) != si || satm(sq) != sq) m_ovf = 1;
         e.i   = satm(si);
         e.q   = satm(sq);
         e.ovf = m_ovf;
         sb.push_back(e);
         m_acc_i = 0;
         m_acc_q = 0;
         m_cnt   = 0;
      end
   endtask

   task automatic step(input bit v, input int s, input int c, input int sn, input bit clr);
      sample_valid = v;
      sample_in    = s[15:0];
      cos_in       = c[15:0];
      sin_in       = sn[15:0];
      clear        = clr;
      if (clr)    model_flush();
      else if (v) model_sample(s, c, sn);
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      clear        = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
   endtask

   task automatic clear_pulse();
      idle(1);
      step(0, 0, 0, 0, 1);
      have_last = 0;
   endtask

   task automatic check_zero_outputs(input string pfx);
      check({pfx, "_i_out"},     $signed(i_out), 0);
      check({pfx, "_q_out"},     $signed(q_out), 0);
      check({pfx, "_out_valid"}, out_valid, 0);
      check({pfx, "_overflow"},  overflow, 0);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (sb.size() == 0) begin
            check("sb_nonempty_on_out_valid", sb.size(), 1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("i_out",    $signed(i_out), e.i);
            check("q_out",    $signed(q_out), e.q);
            check("overflow", overflow, e.ovf);
         end
         if (exp_interval != 0 && have_last)
            check("out_valid_interval", cyc - last_ov, exp_interval);
         last_ov   = cyc;
         have_last = 1;
      end
   end

   initial begin
      rst = 1'b1;
      sample_valid = 1'b0;
      clear = 1'b0;
      sample_in = '0;
      cos_in = '0;
      sin_in = '0;
      decim_ratio = 9'd1;
      model_flush();
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      rst = 1'b0;
      idle(1);

      // Decimation by 1
      exp_interval = 1; have_last = 0;
      for (int k = 0; k < 8; k++) step(1, 16384, 32767, 0, 0);
      idle(4);
      check("decim1_overflow", overflow, 0);

      // Decimation by 4, continuous
      decim_ratio = 9'd4;
      clear_pulse();
      exp_interval = 4;
      for (int k = 0; k < 16; k++) step(1, 4096, 32767, -32767, 0);
      idle(4);

      // Decimation by 4, alternate-cycle valid
      have_last = 0; exp_interval = 8;
      for (int k = 0; k < 16; k++) begin
         step(1, 4096, 32767, -32767, 0);
         step(0, 0, 0, 0, 0);
      end
      idle(4);
      exp_interval = 0;

      // Saturation and sticky overflow, then clear with a discarded sample
      decim_ratio = 9'd2;
      clear_pulse();
      for (int k = 0; k < 4; k++) step(1, 32767, 32767, 0, 0);
      idle(4);
      check("sat_overflow_set", overflow, 1);
      idle(3);
      check("sat_overflow_sticky", overflow, 1);
      step(1, 32767, 32767, 0, 1);
      check("clear_overflow", overflow, 0);
      check("clear_i_hold", $signed(i_out), 32767);
      for (int k = 0; k < 2; k++) step(1, 4096, 32767, 0, 0);
      idle(4);

      // Ratio 0 behaves as 1, extreme operands
      decim_ratio = 9'd0;
      clear_pulse();
      for (int k = 0; k < 3; k++) step(1, -32768, 32767, 0, 0);
      for (int k = 0; k < 3; k++) step(1, -32768, -32767, 0, 0);
      idle(4);
      check("extreme_overflow", overflow, 0);

      // Ratio change mid-period applies at the next period
      decim_ratio = 9'd4;
      clear_pulse();
      for (int k = 0; k < 2; k++) step(1, 4096, 32767, 0, 0);
      decim_ratio = 9'd2;
      for (int k = 0; k < 6; k++) step(1, 4096, 32767, 0, 0);
      idle(4);

      // Reset mid-period discards the partial sum
      decim_ratio = 9'd4;
      clear_pulse();
      for (int k = 0; k < 3; k++) step(1, 4096, 32767, 0, 0);
      idle(1);
      rst = 1'b1;
      model_flush();
      @(posedge clk);
      #1;
      check_zero_outputs("midreset");
      rst = 1'b0;
      idle(1);
      for (int k = 0; k < 4; k++) step(1, 4096, 32767, -32767, 0);
      idle(6);

      check("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got %0d vectors expected completion", n_vec);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
